// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring-divide
// step per clock, single regfile write pulse when the result is ready.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] busa,
    input  logic [XLEN-1:0] busb,
    output logic            busy,
    output logic [4:0]      rw,
    output logic [XLEN-1:0] busw,
    output logic            we
);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] d_q, d_d;
    logic [PW-1:0]   p_q, p_d;
    logic [XLEN-1:0] busw_q, busw_d;

    logic            a_neg, b_neg, special;
    logic [XLEN-1:0] a_mag, b_mag, special_val;
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [PW-1:0]   p_step;

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    endfunction

    // Apply the deferred sign and pick the requested half / quotient / remainder.
    function automatic logic [XLEN-1:0] finish(input logic [2:0] op, input logic neg,
                                               input logic [PW-1:0] p);
        logic [PW-1:0]   prod;
        logic [XLEN-1:0] part;
        if (op[2]) begin
            part = op[1] ? p[PW-1:XLEN] : p[XLEN-1:0];
            return neg ? -part : part;
        end
        prod = neg ? -p : p;
        return (op == 3'b000) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    endfunction

    always_comb begin
        a_neg = a_is_signed(funct3) && busa[XLEN-1];
        b_neg = b_is_signed(funct3) && busb[XLEN-1];
        a_mag = a_neg ? -busa : busa;
        b_mag = b_neg ? -busb : busb;

        special     = 1'b0;
        special_val = '0;
        if (funct3[2] && busb == '0) begin
            special     = 1'b1;
            special_val = funct3[1] ? busa : '1;
        end else if (funct3[2] && !funct3[0] && busa == {1'b1, {(XLEN-1){1'b0}}} && busb == '1) begin
            special     = 1'b1;
            special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end

        mul_sum = {1'b0, p_q[PW-1:XLEN]} + (p_q[0] ? {1'b0, d_q} : '0);
        rem_sh  = p_q[PW-1:XLEN-1];
        if (op_q[2]) begin
            if (rem_sh >= {1'b0, d_q})
                p_step = {rem_sh[XLEN-1:0] - d_q, p_q[XLEN-2:0], 1'b1};
            else
                p_step = {rem_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        end else begin
            p_step = {mul_sum, p_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        d_d     = d_q;
        p_d     = p_q;
        busw_d  = busw_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = funct3;
                    rd_d  = rd;
                    cnt_d = '0;
                    if (funct3[2]) begin
                        d_d   = b_mag;
                        p_d   = {{XLEN{1'b0}}, a_mag};
                        // Remainder follows the dividend; a zero divisor keeps the all-ones quotient.
                        neg_d = funct3[1] ? a_neg : (a_neg ^ b_neg) && (busb != '0);
                    end else begin
                        d_d   = a_mag;
                        p_d   = {{XLEN{1'b0}}, b_mag};
                        neg_d = a_neg ^ b_neg;
                    end
                    if (EARLY_OUT && special) begin
                        busw_d  = special_val;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                p_d   = p_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    busw_d  = finish(op_q, neg_q, p_step);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            d_q     <= '0;
            p_q     <= '0;
            busw_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            d_q     <= d_d;
            p_q     <= p_d;
            busw_q  <= busw_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign we   = (state_q == S_DONE) && (rd_q != 5'd0);
    assign rw   = rd_q;
    assign busw = busw_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, write pulse, stalls and reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] busa, busb;
    logic        busy;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        we;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rd(rd),
        .busa(busa), .busb(busb), .busy(busy), .rw(rw), .busw(busw), .we(we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble the inputs after capture, then watch busy/we cycle by cycle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input int exp_lat,
                          input logic exp_we, input logic [31:0] exp_w, input int poke);
        int          lat, we_cnt, end_c;
        logic [31:0] got_w;
        logic [4:0]  got_r;
        lat = 0; we_cnt = 0; end_c = 0; got_w = '0; got_r = '0;
        @(posedge clk); #1;
        funct3 = f; busa = a; busb = b; rd = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'b011; busa = 32'hDEAD_BEEF; busb = 32'h0BAD_F00D; rd = 5'd31;
        for (int c = 1; c <= 40; c++) begin
            if (!busy) begin
                end_c = c;
                break;
            end
            if (we) begin
                we_cnt++;
                lat   = c;
                got_w = busw;
                got_r = rw;
            end
            if (c == poke) begin
                start = 1'b1; funct3 = 3'b000; busa = 32'd1; busb = 32'd1; rd = 5'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 32'(end_c - 1), 32'(exp_lat));
        if (exp_we) begin
            check({tag, " we_count"}, 32'(we_cnt), 32'd1);
            check({tag, " we_cycle"}, 32'(lat), 32'(exp_lat));
            check({tag, " busw"}, got_w, exp_w);
            check({tag, " rw"}, {27'd0, got_r}, {27'd0, r});
        end else begin
            check({tag, " we_count"}, 32'(we_cnt), 32'd0);
        end
    endtask

    initial begin
        int we_seen;
        rst = 1'b1; start = 1'b0; funct3 = '0; rd = '0; busa = '0; busb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset we", {31'd0, we}, 32'd0);
        check("reset rw", {27'd0, rw}, 32'd0);
        check("reset busw", busw, 32'd0);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  33, 1'b1, 32'hFFFF_FFEB, 0);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 33, 1'b1, 32'h4000_0000, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 33, 1'b1, 32'hFFFF_FFFF, 0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 33, 1'b1, 32'hFFFF_FFFE, 0);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd9,  33, 1'b1, 32'hFFFF_FFFD, 0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd10, 33, 1'b1, 32'hFFFF_FFFF, 0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 33, 1'b1, 32'd14,        0);
        run_op("remu",   3'b111, 32'd100,      32'd7,        5'd12, 33, 1'b1, 32'd2,         0);

        run_op("div0",   3'b100, 32'h0000_0055, 32'd0,        5'd13, 1, 1'b1, 32'hFFFF_FFFF, 0);
        run_op("remu0",  3'b111, 32'h0000_1234, 32'd0,        5'd14, 1, 1'b1, 32'h0000_1234, 0);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 1'b1, 32'h8000_0000, 0);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 1'b1, 32'd0,         0);

        run_op("busy_start", 3'b101, 32'd100, 32'd7, 5'd4, 33, 1'b1, 32'd14, 10);
        run_op("rd0",        3'b000, 32'd9,   32'd9, 5'd0, 33, 1'b0, 32'd0,  0);

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        funct3 = 3'b100; busa = 32'd100; busb = 32'd7; rd = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst we", {31'd0, we}, 32'd0);
        check("midrst busw", busw, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        we_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (we) we_seen++;
            @(posedge clk); #1;
        end
        check("midrst no_we", 32'(we_seen), 32'd0);

        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd3, 33, 1'b1, 32'd12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
